// File: rtl/dyn_add_pkg.sv
// Shared types and constants for the dynamic-adder issue controller.
package dyn_add_pkg;

  localparam int WIDTH = 16;

  // Width of the settle-cycle count N and its ceiling.
  localparam int NW    = 3;
  localparam int N_MAX = 7;

  // Carry-chain segment boundaries: a crossing is counted when the propagate
  // bits at positions b and b+1 are both set.
  localparam int NUM_BOUNDARIES = 3;
  localparam int BOUNDARY [NUM_BOUNDARIES] = '{3, 7, 11};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_HOLD
  } state_t;

endpackage

// File: rtl/dyn_add_lat_class.sv
// Combinational latency classifier: counts carry-chain crossings X from the
// propagate bits straddling each segment boundary and derives the settle
// count N = BASE_WAIT + X, saturated at N_MAX.
module dyn_add_lat_class
  import dyn_add_pkg::*;
#(
  parameter int BASE_WAIT = 1
) (
  input  logic [NUM_BOUNDARIES-1:0][1:0] boundary_p,
  output logic [NW-1:0]                  n
);

  logic [1:0] x;
  int         total;

  // Count boundaries whose propagate pair is 11, then saturate BASE_WAIT + X.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    x = '0;
    for (int i = 0; i < NUM_BOUNDARIES; i++) begin
      if (&boundary_p[i]) x = x + 2'd1;
    end
    total = BASE_WAIT + int'(x);
    n     = (total > N_MAX) ? NW'(N_MAX) : NW'(total);
  end

endmodule

// File: rtl/dyn_add_issue.sv
// Issue controller for a self-timed adder: accepts an operand pair, launches
// the adder, waits a data-dependent number of cycles and holds the result
// until the consumer takes it.
module dyn_add_issue
  import dyn_add_pkg::*;
#(
  parameter int WIDTH     = dyn_add_pkg::WIDTH,
  parameter int BASE_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  output logic             adder_f,
  output logic             adder_request,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [NW-1:0]    out_cycles,
  output logic [15:0]      op_count
);

  state_t                        state, state_nxt;
  logic [NUM_BOUNDARIES-1:0][1:0] boundary_p;
  logic [NW-1:0]                 n_calc;
  logic [NW-1:0]                 n_reg;
  logic [NW-1:0]                 wait_cnt;
  logic                          wait_last;

  // Propagate bits at each segment boundary of the incoming operand pair.
  always_comb begin
    for (int i = 0; i < NUM_BOUNDARIES; i++) begin
      boundary_p[i] = in_a[BOUNDARY[i] +: 2] ^ in_b[BOUNDARY[i] +: 2];
    end
  end

  dyn_add_lat_class #(
    .BASE_WAIT (BASE_WAIT)
  ) u_lat_class (
    .boundary_p (boundary_p),
    .n          (n_calc)
  );

  // wait_cnt counts down from N; the last WAIT cycle is the one at 1.
  assign wait_last = (wait_cnt <= NW'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    else     state <= state_nxt;
  end

  // Next-state and handshake/adder control decode.
  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    adder_f       = 1'b0;
    adder_request = 1'b0;
    out_valid     = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        adder_f   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        adder_request = 1'b1;
        if (wait_last) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, settle countdown, result capture and operation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adder_a    <= '0;
      adder_b    <= '0;
      adder_cin  <= 1'b0;
      n_reg      <= '0;
      wait_cnt   <= '0;
      out_sum    <= '0;
      out_cout   <= 1'b0;
      out_cycles <= '0;
      op_count   <= '0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        adder_a   <= in_a;
        adder_b   <= in_b;
        adder_cin <= in_cin;
        n_reg     <= n_calc;
      end

      if (state == S_LAUNCH)                wait_cnt <= n_reg;
      else if (state == S_WAIT && !wait_last) wait_cnt <= wait_cnt - NW'(1);

      if (state == S_WAIT && wait_last) begin
        out_sum    <= adder_sum;
        out_cout   <= adder_cout;
        out_cycles <= n_reg;
      end

      if (state == S_HOLD && out_ready && op_count != 16'hFFFF) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule
